// File: rtl/uart_rx_framer_if.sv
// Serial receive bundle between the RS232 framer and its surroundings:
// the raw line and baud-generator handshake in, the decoded byte and
// per-frame status flags out.
interface uart_rx_framer_if;
  logic       rs232_rx;
  logic       clk_bps;
  logic       bps_start;
  logic [7:0] rx_data;
  logic       rx_int;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;

  // The framer itself: consumes the line and bit-centre strobes, drives status
  modport master (
    input  rs232_rx,
    input  clk_bps,
    output bps_start,
    output rx_data,
    output rx_int,
    output rx_valid,
    output frame_err,
    output parity_err
  );

  // The surroundings: line driver, baud generator and downstream consumer
  modport slave (
    output rs232_rx,
    output clk_bps,
    input  bps_start,
    input  rx_data,
    input  rx_int,
    input  rx_valid,
    input  frame_err,
    input  parity_err
  );
endinterface

// File: rtl/uart_rx_framer.sv
// RS232 receive framer. The line is resynchronised through a short flop
// chain, a falling edge that survives two clocks starts a frame, and the
// external baud generator's bit-centre strobes step the frame through
// start, 8 data bits (LSB first), optional even parity and stop.
module uart_rx_framer #(
  parameter int PARITY_EN = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_rx_framer_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t     state;
  state_t     state_next;

  logic       s0;
  logic       s1;
  logic       s2;
  logic       s3;
  logic       start_cond;

  logic [3:0] bit_cnt;
  logic [3:0] bit_cnt_next;
  logic [3:0] bit_cnt_inc;
  logic [7:0] shift;
  logic [7:0] shift_next;
  logic       parity_fail;
  logic       parity_fail_next;
  logic       busy;
  logic       busy_next;
  logic [7:0] data_q;
  logic [7:0] data_next;
  logic       valid_q;
  logic       valid_next;
  logic       ferr_q;
  logic       ferr_next;
  logic       perr_q;
  logic       perr_next;

  // Two high samples followed by two low samples; a one-clock dip never
  // shows up in both s1 and s0 at once, so it cannot start a frame.
  assign start_cond = s3 & s2 & ~s1 & ~s0;

  // Counter saturates at 10 (start + 8 data + parity) instead of wrapping
  assign bit_cnt_inc = (bit_cnt < 4'd10) ? bit_cnt + 4'd1 : bit_cnt;

  // Resynchronise the asynchronous line; idle-high so reset looks like idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s0 <= bus.rs232_rx;
      s1 <= s0;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and next-datapath decode; flags default low so they pulse
  always_comb begin
    state_next       = state;
    bit_cnt_next     = bit_cnt;
    shift_next       = shift;
    parity_fail_next = parity_fail;
    busy_next        = busy;
    data_next        = data_q;
    valid_next       = 1'b0;
    ferr_next        = 1'b0;
    perr_next        = 1'b0;

    case (state)
      IDLE: begin
        if (start_cond) begin
          state_next       = START;
          busy_next        = 1'b1;
          bit_cnt_next     = 4'd0;
          parity_fail_next = 1'b0;
        end
      end

      START: begin
        if (bus.clk_bps) begin
          if (s2) begin
            state_next = IDLE;
            busy_next  = 1'b0;
          end else begin
            state_next   = DATA;
            bit_cnt_next = bit_cnt_inc;
          end
        end
      end

      DATA: begin
        if (bus.clk_bps) begin
          shift_next   = {s2, shift[7:1]};
          bit_cnt_next = bit_cnt_inc;
          if (bit_cnt == 4'd8) begin
            state_next = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
      end

      PARITY: begin
        if (bus.clk_bps) begin
          parity_fail_next = (s2 != (^shift));
          bit_cnt_next     = bit_cnt_inc;
          state_next       = STOP;
        end
      end

      STOP: begin
        if (bus.clk_bps) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          if (!s2) begin
            ferr_next = 1'b1;
          end else if (parity_fail) begin
            perr_next = (PARITY_EN != 0);
          end else begin
            data_next  = shift;
            valid_next = 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= 4'd0;
      shift       <= 8'h00;
      parity_fail <= 1'b0;
      busy        <= 1'b0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      bit_cnt     <= bit_cnt_next;
      shift       <= shift_next;
      parity_fail <= parity_fail_next;
      busy        <= busy_next;
      data_q      <= data_next;
      valid_q     <= valid_next;
      ferr_q      <= ferr_next;
      perr_q      <= perr_next;
    end
  end

  assign bus.bps_start  = busy;
  assign bus.rx_int     = busy;
  assign bus.rx_data    = data_q;
  assign bus.rx_valid   = valid_q;
  assign bus.frame_err  = ferr_q;
  assign bus.parity_err = perr_q;

endmodule
